sword_disp_arbiter: RTL

Frame-synchronous arbiter and content scheduler for the SWORD serial display chain. It shares one parallel display word (7-seg or LED) between two requesters, such as the CPU-mapped display register and the debug monitor. It applies per-bit blinking and presents a stable `pdata` to the serial shift-register driver. `pdata` changes only at frame boundaries, so a frame in flight is never torn.

---
 rtl/sword_disp_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sword_disp_arbiter.sv
// sword_disp_arbiter
// Frame-synchronous arbiter and content scheduler for the SWORD serial
// display chain. Two requesters share one parallel display word; the owner's
// word, with per-bit blinking and output polarity applied, is loaded into
// pdata only at frame boundaries so a frame in flight is never torn.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req0/req1  requester wants the display
//   data0/1    requester content, active-high bits
//   gnt0/gnt1  requester owns the display (registered, never both high)
//   blink_mask bits that blink when lit
//   pdata      word to the shift-register driver, polarity applied
//   frame_stb  one-cycle pulse in the cycle after each pdata update
module sword_disp_arbiter #(
   parameter int WIDTH       = 16,
   parameter int FRAME_BITS  = 12,
   parameter int HOLD_FRAMES = 4,
   parameter int BLINK_BITS  = 5,
   parameter int INV         = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt1,
   input  logic [WIDTH-1:0] blink_mask,
   output logic [WIDTH-1:0] pdata,
   output logic             frame_stb
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   localparam logic       INV_L    = (INV != 0);
   localparam logic [7:0] HOLD_MIN = 8'(HOLD_FRAMES - 1);

   logic [FRAME_BITS-1:0] fcnt;
   logic [BLINK_BITS-1:0] bcnt;
   logic [7:0]            hold;
   logic [1:0]            state;
   logic [1:0]            nstate;
   logic                  last;
   logic                  frame_end;
   logic                  hold_met;
   logic                  phase_off;
   logic [WIDTH-1:0]      sel;
   logic [WIDTH-1:0]      lit;

   assign frame_end = &fcnt;
   assign hold_met  = (hold >= HOLD_MIN);
   assign phase_off = bcnt[BLINK_BITS-1];

   // Next-state decision; only applied on frame_end.
   always_comb begin
      nstate = state;
      case (state)
         IDLE: begin
            if (req0 && req1)
               nstate = last ? OWN0 : OWN1;
            else if (req0)
               nstate = OWN0;
            else if (req1)
               nstate = OWN1;
         end
         OWN0: begin
            // Voluntary release hands over without waiting for the hold count.
            if (!req0)
               nstate = req1 ? OWN1 : IDLE;
            else if (req1 && hold_met)
               nstate = OWN1;
         end
         OWN1: begin
            if (!req1)
               nstate = req0 ? OWN0 : IDLE;
            else if (req0 && hold_met)
               nstate = OWN0;
         end
         default: nstate = IDLE;
      endcase
   end

   // Content follows the owner of the state being entered, so data and
   // grant change on the same edge.
   always_comb begin
      sel = '0;
      case (nstate)
         OWN0:    sel = data0;
         OWN1:    sel = data1;
         default: sel = '0;
      endcase
      lit = sel & ~(blink_mask & {WIDTH{phase_off}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt      <= '0;
         bcnt      <= '0;
         hold      <= '0;
         state     <= IDLE;
         last      <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         pdata     <= {WIDTH{INV_L}};
         frame_stb <= 1'b0;
      end else begin
         fcnt      <= fcnt + 1'b1;
         frame_stb <= frame_end;
         if (frame_end) begin
            state <= nstate;
            bcnt  <= bcnt + 1'b1;
            gnt0  <= (nstate == OWN0);
            gnt1  <= (nstate == OWN1);
            pdata <= INV_L ? ~lit : lit;
            if (nstate != state) begin
               hold <= '0;
               if (nstate != IDLE)
                  last <= (nstate == OWN1);
            end else if (hold != 8'hFF) begin
               hold <= hold + 1'b1;
            end
         end
      end
   end

endmodule
